// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Shares a single-port, word-addressed data memory between two requesters.
//   Port A is the CPU load/store stage and port B is the DMA/debug loader.
//   Each access is arbitrated round-robin. A lock lets the winner keep
//   ownership for an atomic read-modify-write sequence, bounded to LOCK_MAX
//   consecutive locked grants. Acknowledge, read data and the misalignment
//   error are registered and returned one cycle after the grant.
//
// Ports
//   clk, rst                system clock, async active-high reset
//   a_req/we/lock/addr/wdata port A request (held until a_ack)
//   a_ack/err/rdata         port A registered completion
//   b_*                     same as port A, for port B
//   mem_we/addr/wdata       memory drive (combinational in the grant cycle)
//   mem_rdata               memory combinational read data at mem_addr
//
// owner (state) | meaning
//   OWN_NONE    | no lock held, plain round-robin between eligible ports
//   OWN_A       | port A holds the lock
//   OWN_B       | port B holds the lock
module data_memory_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int LOCK_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic                 a_lock,
  input  logic [WORD_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_wdata,
  output logic                 a_ack,
  output logic                 a_err,
  output logic [WORD_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic                 b_lock,
  input  logic [WORD_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_wdata,
  output logic                 b_ack,
  output logic                 b_err,
  output logic [WORD_SIZE-1:0] b_rdata,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } own_t;

  own_t                 owner_q, owner_d, winner;
  logic                 last_b_q;
  logic [CW-1:0]        lock_cnt_q, lock_cnt_d;
  logic [CW:0]          lock_inc;
  logic                 a_elig, b_elig;
  logic                 win_we, win_lock, win_misal;
  logic [WORD_SIZE-1:0] win_addr, win_wdata;
  logic [WORD_SIZE-1:0] addr_q, wdata_q;

  always_comb begin
    // A port whose ack is showing this cycle is masked so its held request
    // is not served twice while the requester drops or replaces it.
    a_elig = a_req & ~a_ack & ~rst;
    b_elig = b_req & ~b_ack & ~rst;

    // The lock owner still requesting (even if masked this cycle) blocks the
    // other port; only an owner with req low lets the other port through.
    winner = OWN_NONE;
    case (owner_q)
      OWN_A: begin
        if (a_req)       winner = a_elig ? OWN_A : OWN_NONE;
        else if (b_elig) winner = OWN_B;
      end
      OWN_B: begin
        if (b_req)       winner = b_elig ? OWN_B : OWN_NONE;
        else if (a_elig) winner = OWN_A;
      end
      default: begin
        if (a_elig && b_elig) winner = last_b_q ? OWN_A : OWN_B;
        else if (a_elig)      winner = OWN_A;
        else if (b_elig)      winner = OWN_B;
      end
    endcase

    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_addr  = addr_q;
    win_wdata = wdata_q;
    case (winner)
      OWN_A: begin
        win_we    = a_we;
        win_lock  = a_lock;
        win_addr  = a_addr;
        win_wdata = a_wdata;
      end
      OWN_B: begin
        win_we    = b_we;
        win_lock  = b_lock;
        win_addr  = b_addr;
        win_wdata = b_wdata;
      end
      default: ;
    endcase
    win_misal = |win_addr[1:0];

    mem_we    = (winner != OWN_NONE) & win_we & ~win_misal;
    mem_addr  = win_addr;
    mem_wdata = win_wdata;

    lock_inc   = {1'b0, lock_cnt_q} + (CW+1)'(1);
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    // A grant to the non-owner (owner idle) leaves the lock untouched.
    if (winner != OWN_NONE && (owner_q == OWN_NONE || owner_q == winner)) begin
      if (win_lock && (lock_inc < (CW+1)'(LOCK_MAX))) begin
        owner_d    = winner;
        lock_cnt_d = lock_inc[CW-1:0];
      end else begin
        owner_d    = OWN_NONE;
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      last_b_q   <= 1'b1;
      lock_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_err      <= 1'b0;
      b_err      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      a_ack      <= (winner == OWN_A);
      b_ack      <= (winner == OWN_B);
      a_err      <= (winner == OWN_A) & win_misal;
      b_err      <= (winner == OWN_B) & win_misal;
      if (winner != OWN_NONE) begin
        last_b_q <= (winner == OWN_B);
        addr_q   <= win_addr;
        wdata_q  <= win_wdata;
      end
      if (winner == OWN_A) a_rdata <= mem_rdata;
      if (winner == OWN_B) b_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
  localparam int W  = 32;
  localparam int LM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_req = 0, a_we = 0, a_lock = 0;
  logic [W-1:0] a_addr = 0, a_wdata = 0;
  logic         b_req = 0, b_we = 0, b_lock = 0;
  logic [W-1:0] b_addr = 0, b_wdata = 0;
  logic         a_ack, a_err, b_ack, b_err, mem_we;
  logic [W-1:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  data_memory_arbiter #(.WORD_SIZE(W), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory attached to the arbiter: 64 words, combinational read.
  logic [W-1:0] mem [0:63] = '{default: '0};
  logic         ld_en = 0;
  logic [5:0]   ld_idx = 0;
  logic [W-1:0] ld_val = 0;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (ld_en)       mem[ld_idx] <= ld_val;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the lock (0 none, 1 A, 2 B), who was served
  // last, how many locked grants in a row, the memory image and expected outputs.
  int           m_own = 0, m_last = 2, m_cnt = 0, mw;
  logic [W-1:0] ref_mem [0:63] = '{default: '0};
  logic         e_a_ack = 0, e_b_ack = 0, e_a_err = 0, e_b_err = 0;
  logic [W-1:0] e_a_rdata = 0, e_b_rdata = 0, e_maddr = 0, e_mwdata = 0;

  function automatic int model_pick();
    bit ea, eb;
    ea = a_req && !e_a_ack;
    eb = b_req && !e_b_ack;
    if (m_own == 1) return a_req ? (ea ? 1 : 0) : (eb ? 2 : 0);
    if (m_own == 2) return b_req ? (eb ? 2 : 0) : (ea ? 1 : 0);
    if (ea && eb) return (m_last == 1) ? 2 : 1;
    if (ea) return 1;
    if (eb) return 2;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_own = 0; m_last = 2; m_cnt = 0;
      e_a_ack = 0; e_b_ack = 0; e_a_err = 0; e_b_err = 0;
      e_a_rdata = 0; e_b_rdata = 0; e_maddr = 0; e_mwdata = 0;
    end else begin
      logic [W-1:0] ad, wd, rd;
      logic we, lk, mis;
      mw = model_pick();
      if (ld_en) ref_mem[ld_idx] = ld_val;
      e_a_ack = (mw == 1); e_b_ack = (mw == 2);
      e_a_err = 0; e_b_err = 0;
      if (mw != 0) begin
        ad  = (mw == 1) ? a_addr  : b_addr;
        wd  = (mw == 1) ? a_wdata : b_wdata;
        we  = (mw == 1) ? a_we    : b_we;
        lk  = (mw == 1) ? a_lock  : b_lock;
        mis = (ad % 4) != 0;
        rd  = ref_mem[ad[7:2]];
        if (mw == 1) begin e_a_rdata = rd; e_a_err = mis; end
        else         begin e_b_rdata = rd; e_b_err = mis; end
        if (we && !mis) ref_mem[ad[7:2]] = wd;
        e_maddr = ad; e_mwdata = wd;
        if (m_own == 0 || m_own == mw) begin
          if (lk && m_cnt + 1 < LM) begin m_own = mw; m_cnt = m_cnt + 1; end
          else begin m_own = 0; m_cnt = 0; end
        end
        m_last = mw;
      end
    end
  end

  // Every cycle out of reset: registered outputs and memory drive against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      int pw;
      chkb("a_ack", a_ack, e_a_ack);
      chkb("b_ack", b_ack, e_b_ack);
      chkb("a_err", a_err, e_a_err);
      chkb("b_err", b_err, e_b_err);
      chk("a_rdata", a_rdata, e_a_rdata);
      chk("b_rdata", b_rdata, e_b_rdata);
      pw = model_pick();
      if (pw == 1) begin
        chkb("mem_we", mem_we, a_we && (a_addr % 4) == 0);
        chk("mem_addr", mem_addr, a_addr);
        chk("mem_wdata", mem_wdata, a_wdata);
      end else if (pw == 2) begin
        chkb("mem_we", mem_we, b_we && (b_addr % 4) == 0);
        chk("mem_addr", mem_addr, b_addr);
        chk("mem_wdata", mem_wdata, b_wdata);
      end else begin
        chkb("mem_we_idle", mem_we, 1'b0);
        chk("mem_addr_hold", mem_addr, e_maddr);
        chk("mem_wdata_hold", mem_wdata, e_mwdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, na, nb, prev, order_bad, first_who, acnt, a2_at, b_at, b_early, a_run, mism;

    repeat (3) @(posedge clk);
    #1;
    chkb("rst_a_ack", a_ack, 1'b0);
    chkb("rst_b_ack", b_ack, 1'b0);
    chkb("rst_a_err", a_err, 1'b0);
    chkb("rst_b_err", b_err, 1'b0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_b_rdata", b_rdata, 32'h0);
    chkb("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 0;
    ld_en = 1; ld_idx = 6'd3; ld_val = 32'hDEADBEEF;
    tick();
    ld_en = 0;

    // Single read of word 3.
    a_req = 1; a_we = 0; a_addr = 32'h0C;
    #1 chkb("rd_mem_we", mem_we, 1'b0);
    cyc = 0;
    while (!a_ack && cyc < 10) begin tick(); cyc++; end
    chk("rd_latency", 32'(cyc), 32'd1);
    chk("rd_data", a_rdata, 32'hDEADBEEF);
    chkb("rd_err", a_err, 1'b0);
    a_req = 0;
    tick();

    // Fresh reset so A wins the first tie again.
    rst = 1; tick(); rst = 0;

    // Simultaneous writes.
    a_req = 1; a_we = 1; a_addr = 32'h00; a_wdata = 32'h11;
    b_req = 1; b_we = 1; b_addr = 32'h04; b_wdata = 32'h22;
    tick();
    chkb("sim_a_ack1", a_ack, 1'b1);
    chkb("sim_b_ack1", b_ack, 1'b0);
    a_req = 0; a_we = 0;
    tick();
    chkb("sim_a_ack2", a_ack, 1'b0);
    chkb("sim_b_ack2", b_ack, 1'b1);
    b_req = 0; b_we = 0;
    chk("sim_word0", mem[0], 32'h11);
    chk("sim_word1", mem[1], 32'h22);
    tick();

    // Round-robin with both requests held.
    a_req = 1; a_addr = 32'h20; b_req = 1; b_addr = 32'h24;
    na = 0; nb = 0; prev = 0; order_bad = 0; first_who = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_ack == b_ack) order_bad++;
      else begin
        if (a_ack) na++; else nb++;
        if (first_who == 0) first_who = a_ack ? 1 : 2;
        if ((a_ack ? 1 : 2) == prev) order_bad++;
        prev = a_ack ? 1 : 2;
      end
    end
    a_req = 0; b_req = 0;
    chk("rr_a_count", 32'(na), 32'd4);
    chk("rr_b_count", 32'(nb), 32'd4);
    chk("rr_order", 32'(order_bad), 32'd0);
    chk("rr_first", 32'(first_who), 32'd1);
    tick();

    // Locked read-modify-write by A while B waits.
    b_req = 1; b_we = 0; b_addr = 32'h30;
    a_req = 1; a_we = 0; a_lock = 1; a_addr = 32'h10;
    acnt = 0; a2_at = -1; b_at = -1; b_early = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (b_ack) begin
        if (acnt < 2) b_early = 1;
        if (b_at < 0) b_at = i;
        b_req = 0;
      end
      if (a_ack) begin
        acnt++;
        if (acnt == 1) begin a_we = 1; a_wdata = 32'h55; a_lock = 0; end
        else begin a_req = 0; a_we = 0; a2_at = i; end
      end
    end
    chk("rmw_a_acks", 32'(acnt), 32'd2);
    chk("rmw_b_early", 32'(b_early), 32'd0);
    chk("rmw_a2_at", 32'(a2_at), 32'd3);
    chk("rmw_b_at", 32'(b_at), 32'd4);
    chk("rmw_word4", mem[4], 32'h55);

    // Lock starvation guard.
    a_req = 1; a_lock = 1; a_addr = 32'h14;
    b_req = 1; b_addr = 32'h18;
    a_run = 0; b_at = -1;
    for (int i = 1; i <= 40 && b_at < 0; i++) begin
      tick();
      if (a_ack) a_run++;
      if (b_ack) b_at = i;
    end
    a_req = 0; a_lock = 0; b_req = 0;
    chk("starve_a_run", 32'(a_run), 32'd8);
    chk("starve_b_at", 32'(b_at), 32'd16);
    tick();

    // Misaligned write by B.
    b_req = 1; b_we = 1; b_addr = 32'h06; b_wdata = 32'h99;
    #1 chkb("mis_mem_we", mem_we, 1'b0);
    tick();
    chkb("mis_b_ack", b_ack, 1'b1);
    chkb("mis_b_err", b_err, 1'b1);
    b_req = 0; b_we = 0;
    tick();
    chk("mis_word1", mem[1], 32'h22);

    // Reset in the grant cycle of an A read.
    a_req = 1; a_we = 0; a_addr = 32'h0C;
    #2 rst = 1;
    #1;
    chkb("rmid_a_ack", a_ack, 1'b0);
    chkb("rmid_mem_we", mem_we, 1'b0);
    chk("rmid_mem_addr", mem_addr, 32'h0);
    chk("rmid_a_rdata", a_rdata, 32'h0);
    chk("rmid_b_rdata", b_rdata, 32'h0);
    tick();
    chkb("rmid_a_ack2", a_ack, 1'b0);
    rst = 0; a_req = 0;
    tick();
    chkb("rmid_a_ack3", a_ack, 1'b0);

    mism = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
